// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: word-organised RAM with configurable wait states
// and a two-cycle ERROR response for out-of-range, oversized or misaligned
// accesses. Memory contents survive reset; only the control path is reset.
module ahb_mem_slave #(
    parameter int MEM_WORDS   = 256,  // depth in 32-bit words, power of two (>= 2)
    parameter int WAIT_STATES = 1     // stall cycles per OKAY data phase, 0..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int          AW      = $clog2(MEM_WORDS);
    localparam logic [31:0] DEPTH_U = MEM_WORDS;
    localparam logic [3:0]  WS4     = WAIT_STATES[3:0];

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic            write_q, write_d;
    logic [2:0]      size_q, size_d;

    logic [31:0]     mem_q [MEM_WORDS];

    logic            accept;
    logic            addr_oor;
    logic            misalign;
    logic            req_err;
    logic [AW-1:0]   widx;
    logic [3:0]      be;
    logic            wr_en;
    logic            unused_htrans0;

    // HTRANS[0] only separates NONSEQ from SEQ, which this slave treats alike.
    assign unused_htrans0 = HTRANS[0];

    // A new address phase can only land when this slave is not stalling the bus.
    assign accept = HSEL && HTRANS[1] && HREADYIN &&
                    (state_q == ST_IDLE || state_q == ST_DATA || state_q == ST_ERR2);

    assign addr_oor = {2'b00, HADDR[31:2]} >= DEPTH_U;
    assign misalign = (HSIZE == 3'b001 && HADDR[0]) ||
                      (HSIZE == 3'b010 && HADDR[1:0] != 2'b00);
    assign req_err  = addr_oor || (HSIZE > 3'b010) || misalign;

    assign widx  = addr_q[AW+1:2];
    assign wr_en = (state_q == ST_DATA) && write_q;

    // Control registers; asynchronous reset abandons any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    // Next state, address capture and bus responses.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        size_d    = size_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;

        case (state_q)
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DATA: begin
                HRDATA  = mem_q[widx];
                state_d = ST_IDLE;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Accepting overrides the default exit of IDLE/DATA/ERR2 (pipelining).
        if (accept) begin
            addr_d  = HADDR[AW+1:0];
            write_d = HWRITE;
            size_d  = HSIZE;
            if (req_err) begin
                state_d = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = ST_WAIT;
                cnt_d   = WS4;
            end else begin
                state_d = ST_DATA;
            end
        end
    end

    // Little-endian byte lanes touched by the registered size/offset.
    always_comb begin
        be = 4'b0000;
        case (size_q)
            3'b000:  be = 4'b0001 << addr_q[1:0];
            3'b001:  be = addr_q[1] ? 4'b1100 : 4'b0011;
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Storage array: written at the edge ending DATA, never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[widx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Randomised and directed checks for ahb_mem_slave against a byte-level
// memory model. Two instances: WAIT_STATES=1 (index 0) and 0 (index 1).
module tb_ahb_mem_slave;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct packed {
        logic        rdy;
        logic        resp;
        logic        rd;
        logic [31:0] data;
        logic [31:0] mask;
    } exp_t;

    localparam int WS [2] = '{1, 0};

    logic        clk = 1'b0;
    logic        rst;
    logic        sel_s   [2];
    logic [1:0]  trans_s [2];
    logic        wr_s    [2];
    logic [2:0]  size_s  [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic        rdyin_s [2];
    logic [31:0] rdata_o [2];
    logic        rdy_o   [2];
    logic        resp_o  [2];

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_low  = 0;
    logic [31:0] last_rd [2];
    logic [7:0]  mb [2][1024];
    bit          kb [2][1024];
    txn_t        aq [$];

    always #5 clk = ~clk;

    ahb_mem_slave #(.MEM_WORDS(256), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(rst), .HSEL(sel_s[0]), .HADDR(addr_s[0]),
        .HTRANS(trans_s[0]), .HWRITE(wr_s[0]), .HSIZE(size_s[0]),
        .HWDATA(wdata_s[0]), .HREADYIN(rdyin_s[0]), .HRDATA(rdata_o[0]),
        .HREADYOUT(rdy_o[0]), .HRESP(resp_o[0])
    );

    ahb_mem_slave #(.MEM_WORDS(256), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(rst), .HSEL(sel_s[1]), .HADDR(addr_s[1]),
        .HTRANS(trans_s[1]), .HWRITE(wr_s[1]), .HSIZE(size_s[1]),
        .HWDATA(wdata_s[1]), .HREADYIN(rdyin_s[1]), .HRDATA(rdata_o[1]),
        .HREADYOUT(rdy_o[1]), .HRESP(resp_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    endtask

    function automatic bit is_err(input txn_t t);
        return (t.addr[31:2] >= 30'd256) || (t.size > 3'd2) ||
               (t.size == 3'd1 && t.addr[0]) ||
               (t.size == 3'd2 && t.addr[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] mword(input int d, input logic [31:0] a);
        logic [31:0] w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = mb[d][int'(a[9:2])*4 + i];
        return w;
    endfunction

    function automatic logic [31:0] mmask(input int d, input logic [31:0] a);
        logic [31:0] m = '0;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = kb[d][int'(a[9:2])*4 + i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    task automatic mdl_write(input int d, input txn_t t);
        int nb = 1 << int'(t.size);
        for (int i = 0; i < nb; i++) begin
            int lane = int'(t.addr[1:0]) + i;
            mb[d][int'(t.addr[9:2])*4 + lane] = t.wdata[8*lane +: 8];
            kb[d][int'(t.addr[9:2])*4 + lane] = 1'b1;
        end
    endtask

    task automatic drive(input int d, input txn_t t, input logic rdy);
        sel_s[d]   = t.sel;
        trans_s[d] = t.trans;
        wr_s[d]    = t.wr;
        size_s[d]  = t.size;
        addr_s[d]  = t.addr;
        rdyin_s[d] = rdy;
    endtask

    task automatic add(input logic s, input logic [1:0] tr, input logic w,
                       input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        txn_t t;
        t.sel = s; t.trans = tr; t.wr = w; t.size = sz; t.addr = a; t.wdata = wd;
        aq.push_back(t);
    endtask

    function automatic txn_t rnd_txn();
        txn_t t;
        t.sel   = ($urandom_range(0, 7) != 0);
        t.trans = 2'($urandom_range(0, 3));
        t.wr    = 1'($urandom_range(0, 1));
        t.size  = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
        t.addr  = ($urandom_range(0, 9) == 0) ? (32'h400 | $urandom)
                                              : 32'($urandom_range(0, 255));
        if (t.size <= 3'd2 && $urandom_range(0, 3) != 0)
            t.addr = t.addr & ~((32'd1 << t.size) - 32'd1);
        t.wdata = $urandom;
        return t;
    endfunction

    // Pipelined master: drains aq on instance d, checking every bus cycle.
    task automatic run(input int d);
        exp_t eq [$];
        exp_t e;
        txn_t dp, h, junk;
        bit   dp_vld = 0;
        bit   mrdy;
        int   guard = 0;
        n_low = 0;
        while ((aq.size() > 0 || eq.size() > 0) && guard < 20000) begin
            guard++;
            mrdy = (eq.size() == 0) || eq[0].rdy;
            if (mrdy && aq.size() > 0) drive(d, aq[0], 1'b1);
            else if (mrdy)             drive(d, '0, 1'b1);
            else begin
                junk = rnd_txn();
                drive(d, junk, 1'b0);
            end
            wdata_s[d] = dp_vld ? dp.wdata : $urandom;
            @(negedge clk);
            if (eq.size() > 0) e = eq[0];
            else e = '{rdy: 1'b1, resp: 1'b0, rd: 1'b0, data: 32'h0, mask: 32'hFFFF_FFFF};
            if (rdy_o[d] !== 1'b1) n_low++;
            chk("hreadyout", 32'(rdy_o[d]), 32'(e.rdy));
            chk("hresp", 32'(resp_o[d]), 32'(e.resp));
            if (e.mask != 32'h0) chk("hrdata", rdata_o[d] & e.mask, e.data & e.mask);
            if (e.rd) last_rd[d] = rdata_o[d];
            @(posedge clk);
            if (eq.size() > 0) void'(eq.pop_front());
            if (mrdy && dp_vld) begin
                if (dp.wr) mdl_write(d, dp);
                dp_vld = 0;
            end
            if (mrdy && aq.size() > 0) begin
                h = aq.pop_front();
                if (h.sel && h.trans[1]) begin
                    if (is_err(h)) begin
                        eq.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF});
                        eq.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF});
                    end else begin
                        for (int i = 0; i < WS[d]; i++)
                            eq.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF});
                        eq.push_back('{1'b1, 1'b0, !h.wr, mword(d, h.addr), mmask(d, h.addr)});
                        dp = h;
                        dp_vld = 1;
                    end
                end
            end
            #1;
        end
        if (guard >= 20000) chk("run_bound", 32'(guard), 32'd0);
        drive(d, '0, 1'b1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            drive(d, '0, 1'b1);
            wdata_s[d] = '0;
            last_rd[d] = '0;
            for (int i = 0; i < 1024; i++) begin
                mb[d][i] = 8'h00;
                kb[d][i] = 1'b0;
            end
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_hreadyout", 32'(rdy_o[d]), 32'd1);
            chk("rst_hresp", 32'(resp_o[d]), 32'd0);
            chk("rst_hrdata", rdata_o[d], 32'h0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Give the low 64 words of both instances known contents.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 64; i++) add(1, 2'b10, 1, 3'd2, 32'(i * 4), $urandom);
            run(d);
        end

        // One-wait word write/read and read-after-write in DATA.
        add(1, 2'b10, 1, 3'd2, 32'h10, 32'hDEAD_BEEF);
        add(1, 2'b10, 0, 3'd2, 32'h10, 32'h0);
        run(0);
        chk("ws1_read_deadbeef", last_rd[0], 32'hDEAD_BEEF);

        // Byte write into lane 3.
        add(1, 2'b10, 1, 3'd2, 32'h10, 32'h1122_3344);
        add(1, 2'b11, 1, 3'd0, 32'h13, 32'hAA00_0000);
        add(1, 2'b10, 0, 3'd2, 32'h10, 32'h0);
        run(0);
        chk("byte_lane3", last_rd[0], 32'hAA22_3344);

        // Error responses: out of range and misaligned, reads and writes.
        add(1, 2'b10, 1, 3'd2, 32'h30, 32'h1111_1111);
        add(1, 2'b10, 0, 3'd2, 32'h400, 32'h0);
        add(1, 2'b10, 0, 3'd1, 32'h01, 32'h0);
        add(1, 2'b10, 1, 3'd2, 32'h404, 32'hFFFF_FFFF);
        add(1, 2'b10, 1, 3'd1, 32'h01, 32'hFFFF_FFFF);
        add(1, 2'b10, 1, 3'd3, 32'h00, 32'hFFFF_FFFF);
        add(1, 2'b10, 0, 3'd2, 32'h00, 32'h0);
        run(0);

        // BUSY while selected and NONSEQ while unselected must not write.
        add(1, 2'b01, 1, 3'd2, 32'h10, 32'h0);
        add(0, 2'b10, 1, 3'd2, 32'h10, 32'h0);
        add(1, 2'b10, 0, 3'd2, 32'h10, 32'h0);
        run(0);
        chk("busy_unsel_nowrite", last_rd[0], 32'hAA22_3344);

        // Reset during the wait state of a write abandons it.
        drive(0, '{1'b1, 2'b10, 1'b1, 3'd2, 32'h30, 32'h0}, 1'b1);
        @(posedge clk);
        #1;
        drive(0, '0, 1'b0);
        wdata_s[0] = 32'h1234_5678;
        @(negedge clk);
        chk("pre_rst_wait", 32'(rdy_o[0]), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_hreadyout", 32'(rdy_o[0]), 32'd1);
        chk("mid_rst_hresp", 32'(resp_o[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rdyin_s[0] = 1'b1;
        @(posedge clk);
        #1;
        add(1, 2'b10, 0, 3'd2, 32'h30, 32'h0);
        run(0);
        chk("rst_abandons_write", last_rd[0], 32'h1111_1111);

        // Zero wait states: back-to-back write then read.
        add(1, 2'b10, 1, 3'd2, 32'h20, 32'h5);
        add(1, 2'b10, 0, 3'd2, 32'h20, 32'h0);
        run(1);
        chk("ws0_read", last_rd[1], 32'h0000_0005);
        chk("ws0_no_stall", 32'(n_low), 32'd0);

        // Random mixed traffic on both instances.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 300; i++) aq.push_back(rnd_txn());
            run(d);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ahb_mem_slave.md
AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Interface
REQ-001 SHALL provide parameter MEM_WORDS, default 256, memory depth in 32-bit words (power of two).
REQ-002 SHALL provide parameter WAIT_STATES, default 1, wait cycles inserted per OKAY data phase (0..15).
REQ-003 SHALL provide ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- HSEL  input  1  slave select
- HADDR  input  32  byte address
- HTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  input  1  1=write, 0=read
- HSIZE  input  3  000 byte, 001 halfword, 010 word
- HWDATA  input  32  write data, data phase
- HREADYIN  input  1  bus-level HREADY
- HRDATA  output  32  read data
- HREADYOUT  output  1  data-phase completion
- HRESP  output  1  0=OKAY, 1=ERROR

Function
REQ-004 SHALL accept an address phase only when HSEL=1, HTRANS[1]=1 and HREADYIN=1, registering HADDR, HWRITE and HSIZE.
REQ-005 SHALL treat IDLE/BUSY transfers and unselected cycles as zero-wait OKAY: HREADYOUT=1, HRESP=0, no memory access.
REQ-006 SHALL use states IDLE, WAIT, DATA, ERR1, ERR2.
REQ-007 IDLE: on an accepted valid transfer -> WAIT if WAIT_STATES>0, else DATA; on an accepted erroneous transfer -> ERR1.
REQ-008 WAIT: wait counter loaded with WAIT_STATES at acceptance, decremented each cycle, HREADYOUT=0; -> DATA when counter reaches 1.
REQ-009 DATA: HREADYOUT=1, HRESP=0; transfer completes this cycle; a new address phase accepted in the same cycle follows REQ-007, else -> IDLE.
REQ-010 An access is erroneous when HADDR[31:2] >= MEM_WORDS, HSIZE > 010, or HADDR is misaligned for HSIZE (halfword: HADDR[0]=1; word: HADDR[1:0]!=00).
REQ-011 ERR1: HREADYOUT=0, HRESP=1, -> ERR2; ERR2: HREADYOUT=1, HRESP=1, -> IDLE; no memory access; an address phase presented during ERR2 SHALL be accepted per REQ-004.
REQ-012 Write: memory updated at the clock edge ending DATA, using HWDATA on that cycle; only byte lanes selected by HSIZE and HADDR[1:0] (little-endian) are modified.
REQ-013 Read: HRDATA = full 32-bit word at registered address during DATA; HRDATA = 0 in all other states.
REQ-014 A read accepted in the DATA cycle of a write to the same word SHALL return the newly written data.
REQ-015 Memory contents SHALL NOT be initialised or cleared by reset.
REQ-016 HSEL and HREADYIN low during WAIT/ERR1 SHALL NOT abort the transfer in progress.

Reset
REQ-017 While reset=1: state=IDLE, wait counter=0, registered address/control=0, HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-018 Reset asserted mid-transfer (WAIT, DATA, ERR1, ERR2) SHALL abandon it without a memory write; first cycle after release behaves as IDLE.

Verification
REQ-019 WAIT_STATES=1: word write 0xDEADBEEF to 0x10, then word read 0x10 -> each data phase has one HREADYOUT=0 cycle, read HRDATA=0xDEADBEEF, HRESP=0.
REQ-020 Byte write 0xAA at 0x13 over word 0x11223344 -> subsequent word read of 0x10 returns 0xAA223344.
REQ-021 WAIT_STATES=0: back-to-back NONSEQ write 0x5 to 0x20 then read 0x20 -> read completes the next cycle with HRDATA=0x00000005, HREADYOUT held 1 throughout.
REQ-022 MEM_WORDS=256: read at 0x400 -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); halfword read at 0x01 -> same two-cycle ERROR; memory unchanged.
REQ-023 Reset pulsed during WAIT of a write of 0x12345678 to 0x30 -> HREADYOUT=1, HRESP=0 immediately; later read of 0x30 returns its prior value.
REQ-024 HTRANS=BUSY with HSEL=1, and HSEL=0 with HTRANS=NONSEQ -> HREADYOUT=1, HRESP=0, no memory change.
